// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the two requester handshakes and the shared memory port of
// mem_port_arbiter.
//   slave  modport : arbiter view (requests/memory data in, acks/strobes out)
//   master modport : environment view (drives requests and memory read data)
// Signals:
//   m0_req/m0_we/m0_addr/m0_wdata, m0_ack : master 0 (control unit)
//   m1_req/m1_we/m1_addr/m1_wdata, m1_ack : master 1 (loader / DMA)
//   rdata, gnt, busy                      : shared status back to masters
//   mem_rd, mem_wr, mem_addr, mem_wdata   : memory strobes and latched bus
//   mem_rdata                             : memory read data
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          m0_req;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_ack;
    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_ack;
    logic [DW-1:0] rdata;
    logic [1:0]    gnt;
    logic          busy;
    logic          mem_rd;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  mem_rdata,
        output m0_ack, m1_ack, rdata, gnt, busy,
        output mem_rd, mem_wr, mem_addr, mem_wdata
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output mem_rdata,
        input  m0_ack, m1_ack, rdata, gnt, busy,
        input  mem_rd, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one memory port between master 0 (control unit data/fetch path) and
// master 1 (program loader / DMA). A granted access holds mem_rd or mem_wr for
// MEM_LAT cycles, then pulses the owner's ack for one cycle with read data in
// rdata. All outputs are registered.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : mem_port_arbiter_if.slave (requests, acks, status, memory port)
// Parameters: AW address width, DW data width, MEM_LAT strobe cycles (1..15).
// Build option: define RR_PRIORITY_EN for round-robin arbitration; otherwise
// master 0 has fixed priority over master 1.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int MEM_LAT = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    mem_port_arbiter_if.slave       bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        ACK    = 2'b10
    } state_t;

    // Counter starts at MEM_LAT-1 so the strobes stay up for MEM_LAT cycles.
    localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

    state_t        state_r, state_s;
    logic [3:0]    cnt_r, cnt_s;
    logic          we_r, we_s;
    logic [1:0]    gnt_r, gnt_s;
    logic          m0_ack_r, m0_ack_s;
    logic          m1_ack_r, m1_ack_s;
    logic [DW-1:0] rdata_r, rdata_s;
    logic          busy_r, busy_s;
    logic          mem_rd_r, mem_rd_s;
    logic          mem_wr_r, mem_wr_s;
    logic [AW-1:0] mem_addr_r, mem_addr_s;
    logic [DW-1:0] mem_wdata_r, mem_wdata_s;
    logic          pick_m1_s;

`ifdef RR_PRIORITY_EN
    // 1 = master 1 was served last; resets to 1 so master 0 wins the first tie.
    logic          last_r;

    // Last-owner register, updated when an access is acknowledged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_r <= 1'b1;
        end else if (state_r == ACK) begin
            last_r <= gnt_r[1];
        end else begin
            last_r <= last_r;
        end
    end

    // Round-robin winner: a lone requester wins, a tie goes to the master not served last.
    always_comb begin
        pick_m1_s = 1'b0;
        if (bus.m0_req && bus.m1_req) begin
            pick_m1_s = ~last_r;
        end else begin
            pick_m1_s = bus.m1_req;
        end
    end
`else
    // Fixed-priority winner: master 1 only when master 0 is not requesting.
    always_comb begin
        pick_m1_s = 1'b0;
        if (bus.m0_req) begin
            pick_m1_s = 1'b0;
        end else begin
            pick_m1_s = bus.m1_req;
        end
    end
`endif

    // Next-state and next-output logic for the IDLE/ACCESS/ACK sequence.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        we_s        = we_r;
        gnt_s       = gnt_r;
        m0_ack_s    = 1'b0;
        m1_ack_s    = 1'b0;
        rdata_s     = rdata_r;
        busy_s      = busy_r;
        mem_rd_s    = mem_rd_r;
        mem_wr_s    = mem_wr_r;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;

        case (state_r)
            IDLE: begin
                if (bus.m0_req || bus.m1_req) begin
                    if (pick_m1_s) begin
                        gnt_s       = 2'b10;
                        we_s        = bus.m1_we;
                        mem_addr_s  = bus.m1_addr;
                        mem_wdata_s = bus.m1_wdata;
                    end else begin
                        gnt_s       = 2'b01;
                        we_s        = bus.m0_we;
                        mem_addr_s  = bus.m0_addr;
                        mem_wdata_s = bus.m0_wdata;
                    end
                    mem_rd_s = ~we_s;
                    mem_wr_s = we_s;
                    cnt_s    = CNT_LOAD;
                    busy_s   = 1'b1;
                    state_s  = ACCESS;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS: begin
                if (cnt_r == 4'd0) begin
                    // Last access cycle: memory data is valid now, capture reads only.
                    if (!we_r) begin
                        rdata_s = bus.mem_rdata;
                    end else begin
                        rdata_s = rdata_r;
                    end
                    mem_rd_s = 1'b0;
                    mem_wr_s = 1'b0;
                    m0_ack_s = gnt_r[0];
                    m1_ack_s = gnt_r[1];
                    state_s  = ACK;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            ACK: begin
                gnt_s   = 2'b00;
                busy_s  = 1'b0;
                state_s = IDLE;
            end
            default: begin
                gnt_s    = 2'b00;
                busy_s   = 1'b0;
                mem_rd_s = 1'b0;
                mem_wr_s = 1'b0;
                cnt_s    = 4'd0;
                state_s  = IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= 4'd0;
            we_r        <= 1'b0;
            gnt_r       <= 2'b00;
            m0_ack_r    <= 1'b0;
            m1_ack_r    <= 1'b0;
            rdata_r     <= {DW{1'b0}};
            busy_r      <= 1'b0;
            mem_rd_r    <= 1'b0;
            mem_wr_r    <= 1'b0;
            mem_addr_r  <= {AW{1'b0}};
            mem_wdata_r <= {DW{1'b0}};
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            we_r        <= we_s;
            gnt_r       <= gnt_s;
            m0_ack_r    <= m0_ack_s;
            m1_ack_r    <= m1_ack_s;
            rdata_r     <= rdata_s;
            busy_r      <= busy_s;
            mem_rd_r    <= mem_rd_s;
            mem_wr_r    <= mem_wr_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
        end
    end

    assign bus.m0_ack    = m0_ack_r;
    assign bus.m1_ack    = m1_ack_r;
    assign bus.rdata     = rdata_r;
    assign bus.gnt       = gnt_r;
    assign bus.busy      = busy_r;
    assign bus.mem_rd    = mem_rd_r;
    assign bus.mem_wr    = mem_wr_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory port between two requesters: master 0 is the control unit's data/fetch path, master 1 is the program loader/DMA.
- Each master uses a req/ack handshake. The arbiter grants one master and drives the memory strobes for a fixed number of cycles (MEM_LAT).
- On completion it returns read data to the granted master with a one-cycle ack pulse.
- It sits between CONTROL_UNIT/datapath and the instruction/data memory.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- MEM_LAT, 2, cycles mem_rd/mem_wr stay asserted per access; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- m0_req  input  1  master 0 access request; held until m0_ack.
- m0_we  input  1  master 0: 1 = write, 0 = read.
- m0_addr  input  AW  master 0 address.
- m0_wdata  input  DW  master 0 write data.
- m0_ack  output  1  one-cycle completion pulse to master 0.
- m1_req  input  1  master 1 access request.
- m1_we  input  1  master 1 write enable.
- m1_addr  input  AW  master 1 address.
- m1_wdata  input  DW  master 1 write data.
- m1_ack  output  1  one-cycle completion pulse to master 1.
- rdata  output  DW  registered read data; valid in the ack cycle and held until the next read completes.
- gnt  output  2  one-hot current owner: bit0 = m0, bit1 = m1; 00 when idle.
- busy  output  1  high in ACCESS and ACK states.
- mem_rd  output  1  memory read strobe.
- mem_wr  output  1  memory write strobe.
- mem_addr  output  AW  latched address.
- mem_wdata  output  DW  latched write data.
- mem_rdata  input  DW  memory read data; sampled on the last ACCESS cycle.

Behaviour:
- Reset values: all outputs 0, state IDLE, cnt 0. With RR_PRIORITY_EN, last-owner = m1, so m0 wins the first conflict.
- FSM states: IDLE, ACCESS, ACK. All outputs are registered.
- IDLE
  - If no req: stay in IDLE.
  - If any req: choose a winner and set gnt.
  - Latch addr/we/wdata into mem_addr/mem_wdata plus an internal we.
  - Set mem_rd = ~we and mem_wr = we, load cnt = MEM_LAT-1, go to ACCESS.
- ACCESS
  - Strobes stay asserted. cnt decrements each cycle.
  - When cnt == 0:
    - On a read, capture mem_rdata into rdata.
    - Deassert the strobes.
    - Pulse the winner's ack on the next cycle.
    - Go to ACK.
- ACK
  - The granted ack is high for exactly this cycle.
  - gnt is still valid.
  - Next state is IDLE, where gnt clears.
- Latency: req sampled high in IDLE at edge t → strobes high for edges t+1 .. t+MEM_LAT → ack high for cycle t+MEM_LAT+1. Minimum request-to-request spacing for one master is MEM_LAT+2 cycles.
- Writes leave rdata unchanged.
- Arbitration, default fixed priority: m0 wins a simultaneous request.
- A requester that drops req mid-transaction does not abort it; the access completes and ack still pulses.
- A requester holding req through ack is re-arbitrated in the following IDLE cycle as a new request.
- Inputs are sampled only in IDLE. Changes to addr/wdata/we during ACCESS are ignored.
- The strobes mem_rd and mem_wr are never high together. Both are 0 in IDLE and ACK.
- m0_ack and m1_ack are never high together.
- Reset mid-operation: immediate return to IDLE; strobes, gnt, busy and acks go to 0 asynchronously; no ack is issued for the aborted access.
- MEM_LAT = 1: ACCESS lasts exactly one cycle.

Optional Feature:
- Macro: RR_PRIORITY_EN.
- Defined: round-robin. A 1-bit last-owner register updates in ACK. On a simultaneous request, the master that was not last served wins. A lone requester always wins.
- Undefined: fixed priority, m0 over m1. No last-owner register. m1 can starve while m0 requests back-to-back.

Test Plan:
1. Reset then single read: MEM_LAT=2; m0_req=1, m0_we=0, m0_addr=16'h0010; memory returns 16'hBEEF.
   → mem_rd high 2 cycles with mem_addr=16'h0010; gnt=01; m0_ack one cycle later with rdata=16'hBEEF; gnt=00 afterwards.
2. Single write: m1_req=1, m1_we=1, m1_addr=16'h0020, m1_wdata=16'h1234.
   → mem_wr high 2 cycles with mem_wdata=16'h1234; mem_rd stays 0; m1_ack pulses once; rdata unchanged.
3. Simultaneous requests: both masters req in the same cycle, both held through two transactions.
   → fixed priority build: sequence m0, m1.
   → RR_PRIORITY_EN build: m0 first; then with m0 re-requesting alongside m1, m1 wins the second slot.
4. Input change mid-access: change m0_addr from 16'h0040 to 16'h0050 during ACCESS.
   → mem_addr stays 16'h0040.
   Also drop m0_req mid-access → m0_ack still pulses.
5. Reset mid-access: assert reset during the second ACCESS cycle.
   → mem_rd, gnt, busy = 0 immediately; no ack pulse; after release, a fresh request completes normally.
6. MEM_LAT=1 build: m0 read.
   → strobe high exactly 1 cycle; ack 2 cycles after the request sample edge.
